// File: rtl/harm_pkg.sv
// harm_pkg: shared frame, harmonic, CORDIC and width constants plus the sequencer state encoding
package harm_pkg;
   localparam int          N_SAMPLES  = 17;
   localparam int          NUM_HARM   = 3;
   localparam int          CORDIC_LAT = 16;
   localparam logic [31:0] PHASE_STEP = 32'h0F0F0F0F;
   localparam int          ACC_W      = 40;
   localparam int          HARM_W     = $clog2(NUM_HARM + 1);
   localparam int          CNT_W      = $clog2(N_SAMPLES);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DUMP} state_t;
endpackage

// File: rtl/harmonic_sequencer_if.sv
// harmonic_sequencer_if: sample stream, CORDIC request/return and result stream of the sequencer
//   master: sample source / CORDIC / result sink side; slave: the sequencer
interface harmonic_sequencer_if;
   import harm_pkg::*;
   logic                     sample_valid;
   logic                     sample_ready;
   logic signed [15:0]       sample_in;
   logic [31:0]              cordic_angle;
   logic                     cordic_issue;
   logic signed [16:0]       cordic_cos;
   logic signed [16:0]       cordic_sin;
   logic                     result_valid;
   logic [HARM_W-1:0]        result_harm;
   logic signed [ACC_W-1:0]  result_re;
   logic signed [ACC_W-1:0]  result_im;
   logic                     frame_done;
   logic                     busy;
   modport master (
      output sample_valid, sample_in, cordic_cos, cordic_sin,
      input  sample_ready, cordic_angle, cordic_issue, result_valid, result_harm,
             result_re, result_im, frame_done, busy
   );
   modport slave (
      input  sample_valid, sample_in, cordic_cos, cordic_sin,
      output sample_ready, cordic_angle, cordic_issue, result_valid, result_harm,
             result_re, result_im, frame_done, busy
   );
endinterface

// File: rtl/harm_tag_pipe.sv
// harm_tag_pipe: CORDIC_LAT-deep shift register of {valid, harm, sample} that tracks CORDIC requests in flight
//   clk, reset (async active-low), flush (sync, drops all valid tags)
//   in_*: tag of the request issued this cycle; out_*: tag matching the CORDIC result arriving this cycle
//   pending: a valid tag still sits in any stage before the output
module harm_tag_pipe
   import harm_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [HARM_W-1:0] in_harm,
   input  logic signed [15:0] in_sample,
   output logic              out_valid,
   output logic [HARM_W-1:0] out_harm,
   output logic signed [15:0] out_sample,
   output logic              pending
);
   logic [CORDIC_LAT-1:0] v;
   logic [HARM_W-1:0]     h [CORDIC_LAT];
   logic signed [15:0]    s [CORDIC_LAT];
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v <= '0;
         for (int i = 0; i < CORDIC_LAT; i++) begin
            h[i] <= '0;
            s[i] <= '0;
         end
      end else begin
         v    <= flush ? '0 : {v[CORDIC_LAT-2:0], in_valid};
         h[0] <= in_harm;
         s[0] <= in_sample;
         for (int i = 1; i < CORDIC_LAT; i++) begin
            h[i] <= h[i-1];
            s[i] <= s[i-1];
         end
      end
   end
   assign out_valid  = v[CORDIC_LAT-1];
   assign out_harm   = h[CORDIC_LAT-1];
   assign out_sample = s[CORDIC_LAT-1];
   // The tag at the output is consumed this cycle, so only earlier stages keep the pipe busy.
   assign pending    = |v[CORDIC_LAT-2:0];
endmodule

// File: rtl/harmonic_sequencer.sv
// harmonic_sequencer: shares one fixed-latency CORDIC across NUM_HARM harmonics, accumulates sample*cos/sin per harmonic over a frame, then streams the sums
//   clk, reset (async active-low), clear (sync frame abort, highest priority)
//   bus (slave): sample_valid/ready/in, cordic_angle/issue out, cordic_cos/sin back,
//                result_valid/harm/re/im, frame_done, busy
module harmonic_sequencer
   import harm_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   harmonic_sequencer_if.slave bus
);
   state_t                  state;
   logic signed [15:0]      sample;
   logic [HARM_W-1:0]       k;
   logic [HARM_W-1:0]       nxt_harm;
   logic [CNT_W-1:0]        cnt;
   logic [31:0]             base;
   logic signed [ACC_W-1:0] acc_re [1:NUM_HARM];
   logic signed [ACC_W-1:0] acc_im [1:NUM_HARM];
   logic                    pipe_valid;
   logic [HARM_W-1:0]       pipe_harm;
   logic signed [15:0]      pipe_sample;
   logic                    pending;
   logic signed [32:0]      prod_re;
   logic signed [32:0]      prod_im;
   harm_tag_pipe u_pipe (
      .clk        (clk),
      .reset      (reset),
      .flush      (clear),
      .in_valid   (bus.cordic_issue),
      .in_harm    (k),
      .in_sample  (sample),
      .out_valid  (pipe_valid),
      .out_harm   (pipe_harm),
      .out_sample (pipe_sample),
      .pending    (pending)
   );
   assign prod_re          = 33'(pipe_sample) * 33'(bus.cordic_cos);
   assign prod_im          = 33'(pipe_sample) * 33'(bus.cordic_sin);
   assign nxt_harm         = bus.result_harm + 1'b1;
   assign bus.sample_ready = (state == IDLE) && !clear;
   assign bus.busy         = state != IDLE;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         sample           <= '0;
         k                <= '0;
         cnt              <= '0;
         base             <= '0;
         bus.cordic_issue <= 1'b0;
         bus.cordic_angle <= '0;
         bus.result_valid <= 1'b0;
         bus.result_harm  <= '0;
         bus.result_re    <= '0;
         bus.result_im    <= '0;
         bus.frame_done   <= 1'b0;
         for (int i = 1; i <= NUM_HARM; i++) begin
            acc_re[i] <= '0;
            acc_im[i] <= '0;
         end
      end else if (clear) begin
         state            <= IDLE;
         k                <= '0;
         cnt              <= '0;
         base             <= '0;
         bus.cordic_issue <= 1'b0;
         bus.result_valid <= 1'b0;
         bus.frame_done   <= 1'b0;
         for (int i = 1; i <= NUM_HARM; i++) begin
            acc_re[i] <= '0;
            acc_im[i] <= '0;
         end
      end else begin
         if (pipe_valid) begin
            acc_re[pipe_harm] <= acc_re[pipe_harm] + ACC_W'(prod_re);
            acc_im[pipe_harm] <= acc_im[pipe_harm] + ACC_W'(prod_im);
         end
         case (state)
            IDLE:
               if (bus.sample_valid) begin
                  sample           <= bus.sample_in;
                  state            <= ISSUE;
                  k                <= HARM_W'(1);
                  bus.cordic_issue <= 1'b1;
                  bus.cordic_angle <= base;
               end
            // k*base_phase is built by repeated addition; the 32-bit wrap gives the mod 2^32 for free.
            ISSUE:
               if (k == HARM_W'(NUM_HARM)) begin
                  state            <= DRAIN;
                  k                <= '0;
                  bus.cordic_issue <= 1'b0;
               end else begin
                  k                <= k + 1'b1;
                  bus.cordic_angle <= bus.cordic_angle + base;
               end
            DRAIN:
               if (!pending) begin
                  if (cnt < CNT_W'(N_SAMPLES - 1)) begin
                     cnt   <= cnt + 1'b1;
                     base  <= base + PHASE_STEP;
                     state <= IDLE;
                  end else begin
                     // Harmonic 1 finished accumulating long ago; later harmonics settle before their dump slot.
                     state            <= DUMP;
                     bus.result_valid <= 1'b1;
                     bus.result_harm  <= HARM_W'(1);
                     bus.result_re    <= acc_re[1];
                     bus.result_im    <= acc_im[1];
                     bus.frame_done   <= NUM_HARM == 1;
                  end
               end
            DUMP:
               if (bus.result_harm == HARM_W'(NUM_HARM)) begin
                  state            <= IDLE;
                  cnt              <= '0;
                  base             <= '0;
                  bus.result_valid <= 1'b0;
                  bus.frame_done   <= 1'b0;
                  for (int i = 1; i <= NUM_HARM; i++) begin
                     acc_re[i] <= '0;
                     acc_im[i] <= '0;
                  end
               end else begin
                  bus.result_harm <= nxt_harm;
                  bus.result_re   <= acc_re[nxt_harm];
                  bus.result_im   <= acc_im[nxt_harm];
                  bus.frame_done  <= nxt_harm == HARM_W'(NUM_HARM);
               end
         endcase
      end
   end
endmodule

// File: tb/tb_harmonic_sequencer.sv
// tb_harmonic_sequencer: random and directed stimulus against a frame-level behavioural model with a fixed-latency CORDIC stub
module tb_harmonic_sequencer;
   import harm_pkg::*;
   typedef struct {longint cyc; logic [31:0] ang;} iss_t;
   typedef struct {longint cyc; int harm; longint re; longint im; bit fd;} res_t;
   logic clk = 1'b0;
   logic reset;
   logic clear;
   harmonic_sequencer_if bus ();
   harmonic_sequencer dut (.clk(clk), .reset(reset), .clear(clear), .bus(bus.slave));
   always #5 clk = ~clk;
   int          tests = 0;
   int          fails = 0;
   int          mode = 1;
   longint      cyc = 0;
   longint      free_at = 0;
   int          fn = 0;
   int          fs [N_SAMPLES];
   iss_t        exp_iss [$];
   res_t        exp_res [$];
   res_t        rr [$];
   logic [31:0] ang_log [$];
   task automatic chk(input string n, input logic signed [63:0] a, input logic signed [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", n, a, e, cyc);
      end
   endtask
   function automatic logic [31:0] ang(input int k, input int i);
      longint p;
      p = longint'(k) * longint'(i) * longint'(PHASE_STEP);
      return p[31:0];
   endfunction
   // mode 0: ideal CORDIC scaled by 60000; mode 1: cos=1 sin=0; mode 2: cos=sin=-65536
   function automatic int trig(input logic [31:0] a, input int m, input bit is_sin);
      real th;
      real x;
      if (m == 1) return is_sin ? 0 : 1;
      if (m == 2) return -65536;
      th = 6.283185307179586 * real'(longint'(a)) / 4294967296.0;
      x = 60000.0 * (is_sin ? $sin(th) : $cos(th));
      return $rtoi(x >= 0.0 ? x + 0.5 : x - 0.5);
   endfunction
   // CORDIC stub: answer CORDIC_LAT cycles after each issue, noise otherwise
   logic [CORDIC_LAT-1:0] sv;
   logic [31:0]           sa [CORDIC_LAT];
   always @(posedge clk) begin
      cyc++;
      for (int i = CORDIC_LAT - 1; i > 0; i--) begin
         sv[i] = sv[i-1];
         sa[i] = sa[i-1];
      end
      sv[0] = bus.cordic_issue;
      sa[0] = bus.cordic_angle;
      bus.cordic_cos <= sv[CORDIC_LAT-1] ? 17'(trig(sa[CORDIC_LAT-1], mode, 0)) : 17'($urandom);
      bus.cordic_sin <= sv[CORDIC_LAT-1] ? 17'(trig(sa[CORDIC_LAT-1], mode, 1)) : 17'($urandom);
   end
   bit     e_rdy, e_iss, e_res, e_fd;
   longint sre, sim;
   always @(negedge clk) begin
      if (!reset) begin
         exp_iss.delete();
         exp_res.delete();
         free_at = cyc;
         fn = 0;
      end else begin
         e_rdy = cyc >= free_at && !clear;
         chk("sample_ready", bus.sample_ready, e_rdy);
         chk("busy", bus.busy, cyc < free_at);
         e_iss = exp_iss.size() != 0 && exp_iss[0].cyc == cyc;
         chk("cordic_issue", bus.cordic_issue, e_iss);
         if (e_iss) begin
            chk("cordic_angle", bus.cordic_angle, exp_iss[0].ang);
            void'(exp_iss.pop_front());
         end
         if (bus.cordic_issue) ang_log.push_back(bus.cordic_angle);
         e_res = exp_res.size() != 0 && exp_res[0].cyc == cyc;
         e_fd = 0;
         if (e_res) e_fd = exp_res[0].fd;
         chk("result_valid", bus.result_valid, e_res);
         chk("frame_done", bus.frame_done, e_fd);
         if (e_res) begin
            chk("result_harm", bus.result_harm, exp_res[0].harm);
            chk("result_re", $signed(bus.result_re), exp_res[0].re);
            chk("result_im", $signed(bus.result_im), exp_res[0].im);
            void'(exp_res.pop_front());
         end
         if (bus.result_valid)
            rr.push_back('{cyc, int'(bus.result_harm), $signed(bus.result_re), $signed(bus.result_im), bus.frame_done});
         if (clear) begin
            exp_iss.delete();
            exp_res.delete();
            free_at = cyc + 1;
            fn = 0;
         end else if (bus.sample_valid && e_rdy) begin
            for (int k = 1; k <= NUM_HARM; k++) exp_iss.push_back('{cyc + k, ang(k, fn)});
            fs[fn] = int'(bus.sample_in);
            if (fn == N_SAMPLES - 1) begin
               for (int h = 1; h <= NUM_HARM; h++) begin
                  sre = 0;
                  sim = 0;
                  for (int i = 0; i < N_SAMPLES; i++) begin
                     sre += longint'(fs[i]) * trig(ang(h, i), mode, 0);
                     sim += longint'(fs[i]) * trig(ang(h, i), mode, 1);
                  end
                  exp_res.push_back('{cyc + NUM_HARM + CORDIC_LAT + h, h, sre, sim, h == NUM_HARM});
               end
               free_at = cyc + NUM_HARM + CORDIC_LAT + 1 + NUM_HARM;
               fn = 0;
            end else begin
               free_at = cyc + NUM_HARM + CORDIC_LAT + 1;
               fn++;
            end
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic signed [15:0] v, input bit keep, output longint ac);
      int n;
      bit a;
      n = 0;
      a = 0;
      ac = 0;
      bus.sample_valid = 1'b1;
      bus.sample_in = v;
      while (!a && n < 300) begin
         @(negedge clk);
         a = bus.sample_ready;
         ac = cyc;
         tick();
         n++;
      end
      if (!a) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: got no accept in %0d cycles, want accept", n);
      end
      if (!keep) bus.sample_valid = 1'b0;
   endtask
   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_iss.size() != 0 || exp_res.size() != 0 || cyc < free_at) && n < 200) begin
         tick();
         n++;
      end
      chk("idle_timeout", n < 200, 1);
   endtask
   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask
   task automatic check_reset_outputs(input string n);
      chk({n, "_ready"}, bus.sample_ready, 1);
      chk({n, "_issue"}, bus.cordic_issue, 0);
      chk({n, "_angle"}, bus.cordic_angle, 0);
      chk({n, "_rvalid"}, bus.result_valid, 0);
      chk({n, "_harm"}, bus.result_harm, 0);
      chk({n, "_re"}, $signed(bus.result_re), 0);
      chk({n, "_im"}, $signed(bus.result_im), 0);
      chk({n, "_done"}, bus.frame_done, 0);
      chk({n, "_busy"}, bus.busy, 0);
   endtask
   task automatic async_reset(input string n);
      #2 reset = 1'b0;
      #1 check_reset_outputs(n);
      @(negedge clk);
      #2 reset = 1'b1;
      tick();
   endtask
   logic [31:0]        exp_ang [6] = '{32'h0, 32'h0, 32'h0, 32'h0F0F0F0F, 32'h1E1E1E1E, 32'h2D2D2D2D};
   logic signed [15:0] pat [N_SAMPLES];
   longint             ac, prev;
   int                 b;
   res_t               ref_res [NUM_HARM];
   initial begin
      reset = 1'b1;
      clear = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample_in = '0;
      #1 reset = 1'b0;
      #2 check_reset_outputs("por");
      @(negedge clk);
      #2 reset = 1'b1;
      tick();
      // constant stub, 17 samples of 100
      mode = 1;
      b = rr.size();
      for (int i = 0; i < N_SAMPLES; i++) begin
         push(16'sd100, 0, ac);
         repeat ($urandom_range(0, 3)) tick();
      end
      wait_idle();
      chk("A_count", rr.size() - b, 3);
      if (rr.size() - b == 3)
         for (int j = 0; j < 3; j++) begin
            chk("A_harm", rr[b+j].harm, j + 1);
            chk("A_re", rr[b+j].re, 1700);
            chk("A_im", rr[b+j].im, 0);
            chk("A_done", rr[b+j].fd, j == 2);
            chk("A_spacing", rr[b+j].cyc - rr[b].cyc, j);
         end
      // angles of sample index 0 and 1
      mode = 0;
      ang_log.delete();
      push(16'($urandom), 0, ac);
      push(16'($urandom), 0, ac);
      wait_idle();
      chk("ang_count", ang_log.size(), 6);
      if (ang_log.size() == 6)
         for (int i = 0; i < 6; i++) chk("ang_literal", ang_log[i], exp_ang[i]);
      for (int i = 2; i < N_SAMPLES; i++) push(16'($urandom), 0, ac);
      wait_idle();
      // sample_valid held high over two periodic frames
      for (int i = 0; i < N_SAMPLES; i++) pat[i] = 16'($urandom);
      b = rr.size();
      prev = 0;
      for (int i = 0; i < 2 * N_SAMPLES; i++) begin
         push(pat[i % N_SAMPLES], 1, ac);
         if (i > 0)
            chk("held_gap", ac - prev, (i % N_SAMPLES == 0) ? NUM_HARM + CORDIC_LAT + 1 + NUM_HARM : NUM_HARM + CORDIC_LAT + 1);
         prev = ac;
      end
      bus.sample_valid = 1'b0;
      wait_idle();
      chk("held_count", rr.size() - b, 2 * NUM_HARM);
      if (rr.size() - b == 2 * NUM_HARM)
         for (int j = 0; j < NUM_HARM; j++) begin
            chk("periodic_re", rr[b+NUM_HARM+j].re, rr[b+j].re);
            chk("periodic_im", rr[b+NUM_HARM+j].im, rr[b+j].im);
         end
      // fresh reference frame, then a cleared partial frame, then the same frame again
      async_reset("rst2");
      for (int i = 0; i < N_SAMPLES; i++) pat[i] = 16'($urandom);
      b = rr.size();
      for (int i = 0; i < N_SAMPLES; i++) push(pat[i], 0, ac);
      wait_idle();
      chk("ref_count", rr.size() - b, NUM_HARM);
      for (int j = 0; j < NUM_HARM && b + j < rr.size(); j++) ref_res[j] = rr[b+j];
      for (int i = 0; i < 5; i++) push(16'($urandom), 0, ac);
      repeat (8) tick();
      pulse_clear();
      wait_idle();
      bus.sample_valid = 1'b1;
      bus.sample_in = 16'sd1234;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      bus.sample_valid = 1'b0;
      b = rr.size();
      repeat (40) tick();
      chk("clear_no_result", rr.size() - b, 0);
      for (int i = 0; i < N_SAMPLES; i++) push(pat[i], 0, ac);
      wait_idle();
      chk("after_clear_count", rr.size() - b, NUM_HARM);
      if (rr.size() - b == NUM_HARM)
         for (int j = 0; j < NUM_HARM; j++) begin
            chk("after_clear_re", rr[b+j].re, ref_res[j].re);
            chk("after_clear_im", rr[b+j].im, ref_res[j].im);
         end
      // clear on the second dump cycle cuts the stream short
      b = rr.size();
      for (int i = 0; i < N_SAMPLES; i++) push(16'($urandom), 0, ac);
      for (int n = 0; n < 100 && rr.size() == b; n++) tick();
      pulse_clear();
      wait_idle();
      repeat (5) tick();
      chk("dump_clear_count", rr.size() - b, 2);
      if (rr.size() - b == 2) chk("dump_clear_done", rr[b+1].fd, 0);
      // full-scale input
      mode = 2;
      b = rr.size();
      for (int i = 0; i < N_SAMPLES; i++) push(-16'sd32768, 0, ac);
      wait_idle();
      chk("fs_count", rr.size() - b, NUM_HARM);
      if (rr.size() - b == NUM_HARM)
         for (int j = 0; j < NUM_HARM; j++) begin
            chk("fs_re", rr[b+j].re, 64'sd36507222016);
            chk("fs_im", rr[b+j].im, 64'sd36507222016);
         end
      // reset while in ISSUE
      mode = 0;
      push(16'($urandom), 0, ac);
      async_reset("rst_issue");
      // random samples, gaps and clears
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) == 0) pulse_clear();
         push(16'($urandom), 0, ac);
         repeat ($urandom_range(0, 25)) tick();
      end
      for (int i = fn; i < N_SAMPLES && fn != 0; i++) push(16'($urandom), 0, ac);
      wait_idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
